reg_scoreboard: RTL and testbench

Per-register scoreboard for the 5-stage ARM-subset pipeline. It sits between ID and EXE and is the writer-side counterpart to read-side hazard checking.
- Records destination registers of issued instructions as pending.
- Clears them when the WB stage retires.
- Raises stall for an ID-stage instruction whose sources are still pending.
- Replaces fixed EXE/MEM destination comparison, so any number of stages or multi-cycle units can be tracked.

---
 rtl/sb_pkg.sv | 13 +
 rtl/sb_entry.sv | 41 ++++
 rtl/reg_scoreboard.sv | 72 +++++++
 tb/tb_reg_scoreboard.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared widths, limits and types for the register scoreboard.
//   ADDR_W  register address width
//   NREG    architectural registers tracked (2**ADDR_W)
//   CNT_W   per-register pending-write counter width
//   CNT_MAX saturation value of a pending-write counter
package sb_pkg;
  localparam int ADDR_W = 4;
  localparam int NREG = 1 << ADDR_W;
  localparam int CNT_W = 2;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [CNT_W-1:0] sb_cnt_t;
  localparam sb_cnt_t CNT_MAX = '1;
endpackage

// File: rtl/sb_entry.sv
// sb_entry: pending-write counter for one architectural register.
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   flush     in   clear the counter at the next edge
//   inc       in   an instruction writing this register issues
//   dec       in   WB retires a write to this register (raw, ungated)
//   cnt       out  current pending-write count
//   busy      out  cnt != 0
//   at_max    out  cnt == CNT_MAX
//   err_pulse out  retire with nothing pending, or increment at saturation
module sb_entry
  import sb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             at_max,
  output logic             err_pulse
);
  sb_cnt_t cnt_q, cnt_d;
  logic dec_ok, up, dn;
  assign busy = cnt_q != '0;
  assign at_max = cnt_q == CNT_MAX;
  // A retire only counts when something is pending; same-cycle inc and dec cancel.
  assign dec_ok = dec & busy;
  assign up = inc & ~dec_ok;
  assign dn = dec_ok & ~inc;
  assign err_pulse = (dec & ~busy) | (up & at_max);
  assign cnt = cnt_q;
  always_comb begin
    cnt_d = flush ? '0 : (up & ~at_max) ? cnt_q + 1'b1 : dn ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard between ID and EXE.
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   clear all pending state (pipeline restart)
//   id_valid   in   ID holds a valid instruction
//   id_wb_en   in   ID instruction writes a register
//   id_dest    in   ID destination register
//   id_two_src in   src2 is a real operand
//   id_src1    in   first source register
//   id_src2    in   second source register
//   wb_valid   in   WB retires a register write this cycle
//   wb_dest    in   retired destination
//   stall      out  hold IF/ID, bubble into EXE
//   busy_vec   out  bit r set while register r has writes pending
//   sb_err     out  sticky overflow / retire-without-pending flag
// Optional macro SB_WB_BYPASS_EN: a source with exactly one pending write that
// is retiring this cycle is not treated as busy (register file writes first half).
module reg_scoreboard
  import sb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_wb_en,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_two_src,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  output logic              stall,
  output logic [NREG-1:0]   busy_vec,
  output logic              sb_err
);
  sb_cnt_t cnt_w [NREG];
  logic [NREG-1:0] max_w, err_w, inc_w, dec_w;
  logic src1_busy, src2_busy, issue_fire, sb_err_q, sb_err_d;
`ifdef SB_WB_BYPASS_EN
  assign src1_busy = cnt_w[id_src1] != '0 && !(wb_valid && wb_dest == id_src1 && cnt_w[id_src1] == sb_cnt_t'(1));
  assign src2_busy = cnt_w[id_src2] != '0 && !(wb_valid && wb_dest == id_src2 && cnt_w[id_src2] == sb_cnt_t'(1));
`else
  assign src1_busy = cnt_w[id_src1] != '0;
  assign src2_busy = cnt_w[id_src2] != '0;
`endif
  // The at_max term turns a saturating write-after-write into a stall.
  assign stall = id_valid & (src1_busy | (id_two_src & src2_busy) | (id_wb_en & max_w[id_dest]));
  assign issue_fire = id_valid & id_wb_en & ~stall & ~flush;
  for (genvar i = 0; i < NREG; i++) begin : g_ent
    assign inc_w[i] = issue_fire & (id_dest == reg_addr_t'(i));
    assign dec_w[i] = wb_valid & ~flush & (wb_dest == reg_addr_t'(i));
    sb_entry u_ent (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .inc      (inc_w[i]),
      .dec      (dec_w[i]),
      .cnt      (cnt_w[i]),
      .busy     (busy_vec[i]),
      .at_max   (max_w[i]),
      .err_pulse(err_w[i])
    );
  end
  always_comb begin
    sb_err_d = sb_err_q | (|err_w);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_err_q <= 1'b0;
    else sb_err_q <= sb_err_d;
  end
  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table-driven check of reg_scoreboard with a post-edge scoreboard queue.
module tb_reg_scoreboard;
`ifdef SB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, id_valid = 1'b0, id_wb_en = 1'b0, id_two_src = 1'b0, wb_valid = 1'b0;
  logic [3:0] id_dest = '0, id_src1 = '0, id_src2 = '0, wb_dest = '0;
  logic stall, sb_err;
  logic [15:0] busy_vec;
  int n_vec = 0, n_err = 0;
  typedef struct {
    logic fl, iv, we;
    logic [3:0] d;
    logic ts;
    logic [3:0] s1, s2;
    logic wv;
    logic [3:0] wd;
    logic e_stall;
    logic [15:0] e_busy;
    logic e_err;
  } v_t;
  typedef struct {
    logic [15:0] busy;
    logic err;
    int idx;
  } exp_t;
  v_t tv[$];
  exp_t sbq[$];
  reg_scoreboard dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_wb_en  (id_wb_en),
    .id_dest   (id_dest),
    .id_two_src(id_two_src),
    .id_src1   (id_src1),
    .id_src2   (id_src2),
    .wb_valid  (wb_valid),
    .wb_dest   (wb_dest),
    .stall     (stall),
    .busy_vec  (busy_vec),
    .sb_err    (sb_err)
  );
  always #5 clk = ~clk;
  function automatic v_t mk(input logic fl, iv, we, input logic [3:0] d, input logic ts,
                            input logic [3:0] s1, s2, input logic wv, input logic [3:0] wd,
                            input logic st, input logic [15:0] bz, input logic er);
    v_t v;
    v.fl = fl; v.iv = iv; v.we = we; v.d = d; v.ts = ts; v.s1 = s1; v.s2 = s2;
    v.wv = wv; v.wd = wd; v.e_stall = st; v.e_busy = bz; v.e_err = er;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input v_t v);
    flush = v.fl; id_valid = v.iv; id_wb_en = v.we; id_dest = v.d; id_two_src = v.ts;
    id_src1 = v.s1; id_src2 = v.s2; wb_valid = v.wv; wb_dest = v.wd;
  endtask
  task automatic apply(input v_t v, input int k);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.busy = v.e_busy; e.err = v.e_err; e.idx = k;
    sbq.push_back(e);
    #1 chk($sformatf("v%0d stall", k), 32'(stall), 32'(v.e_stall));
    @(posedge clk);
    #1;
    if (sbq.size() == 0) chk($sformatf("v%0d queue", k), 32'd0, 32'd1);
    else begin
      e = sbq.pop_front();
      chk($sformatf("v%0d busy_vec", e.idx), 32'(busy_vec), 32'(e.busy));
      chk($sformatf("v%0d sb_err", e.idx), 32'(sb_err), 32'(e.err));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tv.push_back(mk(0,1,0,4'd0,1,4'd3,4'd4,0,4'd0, 0,16'h0000,0));
    tv.push_back(mk(0,1,1,4'd5,0,4'd0,4'd0,0,4'd0, 0,16'h0020,0));
    tv.push_back(mk(0,1,0,4'd0,0,4'd5,4'd0,0,4'd0, 1,16'h0020,0));
    tv.push_back(mk(0,1,1,4'd8,0,4'd5,4'd0,0,4'd0, 1,16'h0020,0));
    tv.push_back(mk(0,1,0,4'd0,0,4'd5,4'd0,1,4'd5, !BYP,16'h0000,0));
    tv.push_back(mk(0,1,1,4'd8,0,4'd5,4'd0,0,4'd0, 0,16'h0100,0));
    tv.push_back(mk(0,1,1,4'd7,0,4'd0,4'd0,0,4'd0, 0,16'h0180,0));
    tv.push_back(mk(0,1,0,4'd0,0,4'd0,4'd7,0,4'd0, 0,16'h0180,0));
    tv.push_back(mk(0,1,0,4'd0,1,4'd0,4'd7,0,4'd0, 1,16'h0180,0));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd7, 0,16'h0100,0));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd8, 0,16'h0000,0));
    tv.push_back(mk(0,1,1,4'd2,0,4'd0,4'd0,0,4'd0, 0,16'h0004,0));
    tv.push_back(mk(0,1,1,4'd2,0,4'd0,4'd0,0,4'd0, 0,16'h0004,0));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd2, 0,16'h0004,0));
    tv.push_back(mk(0,1,1,4'd2,0,4'd0,4'd0,1,4'd2, 0,16'h0004,0));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd2, 0,16'h0000,0));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd9, 0,16'h0000,1));
    tv.push_back(mk(0,1,1,4'd1,0,4'd0,4'd0,0,4'd0, 0,16'h0002,1));
    tv.push_back(mk(0,1,1,4'd1,0,4'd0,4'd0,0,4'd0, 0,16'h0002,1));
    tv.push_back(mk(0,1,1,4'd1,0,4'd0,4'd0,0,4'd0, 0,16'h0002,1));
    tv.push_back(mk(0,1,1,4'd1,0,4'd0,4'd0,0,4'd0, 1,16'h0002,1));
    tv.push_back(mk(0,0,1,4'd1,0,4'd1,4'd1,0,4'd0, 0,16'h0002,1));
    tv.push_back(mk(0,1,0,4'd0,0,4'd1,4'd0,1,4'd1, 1,16'h0002,1));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd1, 0,16'h0002,1));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd1, 0,16'h0000,1));
    tv.push_back(mk(0,1,1,4'd10,0,4'd0,4'd0,0,4'd0, 0,16'h0400,1));
    tv.push_back(mk(1,1,1,4'd11,0,4'd0,4'd0,1,4'd10, 0,16'h0000,1));
    tv.push_back(mk(0,0,0,4'd0,0,4'd0,4'd0,1,4'd10, 0,16'h0000,1));
    tv.push_back(mk(0,1,1,4'd15,0,4'd0,4'd0,0,4'd0, 0,16'h8000,1));
    tv.push_back(mk(0,1,0,4'd0,0,4'd15,4'd0,0,4'd0, 1,16'h8000,1));
    tv.push_back(mk(0,1,0,4'd0,1,4'd0,4'd15,1,4'd15, !BYP,16'h0000,1));
    tv.push_back(mk(0,1,1,4'd6,0,4'd0,4'd0,0,4'd0, 0,16'h0040,1));
    tv.push_back(mk(0,1,0,4'd0,0,4'd6,4'd0,1,4'd6, !BYP,16'h0000,1));
    // Reset state while rst is held low, with a valid ID instruction presented.
    id_valid = 1'b1; id_src1 = 4'd3; id_src2 = 4'd4; id_two_src = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy_vec", 32'(busy_vec), 32'h0);
    chk("reset stall", 32'(stall), 32'h0);
    chk("reset sb_err", 32'(sb_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    foreach (tv[k]) apply(tv[k], k);
    // Asynchronous reset between clock edges clears pending state and sb_err at once.
    apply(mk(0,1,1,4'd3,0,4'd0,4'd0,0,4'd0, 0,16'h0008,1), 100);
    id_valid = 1'b1; id_wb_en = 1'b0; id_src1 = 4'd3; id_two_src = 1'b0;
    #1 chk("pre-reset stall", 32'(stall), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("async busy_vec", 32'(busy_vec), 32'h0);
    chk("async stall", 32'(stall), 32'h0);
    chk("async sb_err", 32'(sb_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    apply(mk(0,1,0,4'd0,0,4'd3,4'd0,0,4'd0, 0,16'h0000,0), 101);
    chk("queue drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
